sta_output_requantizer: RTL and testbench

Downstream neighbour of the 4x4 systolic tensor array. On a `start` pulse it snapshots the 16 int32 accumulator outputs (C0..C3) together with the per-PE mask. It requantizes each unmasked value to int8 (fixed-point multiply, rounding shift, zero-point add, activation clamp) and streams the results out one per cycle in row-major order over a valid/ready interface. Because the snapshot is taken at `start`, the array is free to load the next tile's biases while the drain is still in progress.

---
 rtl/sta_output_requantizer.sv | 165 ++++++++++++++++
 tb/tb_sta_output_requantizer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sta_output_requantizer.sv
// sta_output_requantizer: snapshots the systolic array accumulators on start and streams
// int8 requantized results in row-major order over a valid/ready port.
//
// state    | meaning
// ST_IDLE  | waiting for start; capture happens on the start cycle
// ST_RUN   | walking idx 0..N*N-1, issuing unmasked elements into S1
// ST_DRAIN | waiting for S1 and the output register to empty, then pulse done
module sta_output_requantizer #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N*ACC_W-1:0]   C0,
  input  logic [N*ACC_W-1:0]   C1,
  input  logic [N*ACC_W-1:0]   C2,
  input  logic [N*ACC_W-1:0]   C3,
  input  logic [N*N-1:0]       pe_mask,
  input  logic [31:0]          q_mult,
  input  logic [4:0]           q_shift,
  input  logic [OUT_W-1:0]     out_zp,
  input  logic [OUT_W-1:0]     act_min,
  input  logic [OUT_W-1:0]     act_max,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_row,
  output logic [$clog2(N)-1:0] out_col,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = $clog2(N*N);
  localparam int RC_W  = $clog2(N);
  localparam int PW    = ACC_W + 32;
  localparam int WW    = PW + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [ACC_W-1:0] r_acc [N*N];
  logic [N*N-1:0]          r_mask;
  logic signed [31:0]      r_q_mult;
  logic [4:0]              r_q_shift;
  logic signed [OUT_W-1:0] r_zp, r_act_min, r_act_max;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_s1_valid;
  logic signed [PW-1:0]    r_s1_prod;
  logic [IDX_W-1:0]        r_s1_idx;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_out_data;
  logic [IDX_W-1:0]        r_out_idx;

  logic                    w_stall, w_capture, w_step, w_last;
  logic signed [ACC_W-1:0] w_acc;
  logic [5:0]              w_shift;
  logic signed [WW-1:0]    w_prod_ext, w_half, w_sum, w_rnd, w_v, w_min, w_max;
  logic [OUT_W-1:0]        w_clamped;

  assign w_stall = r_out_valid && !out_ready;
  assign w_last  = (r_idx == IDX_W'(N*N-1));
  assign w_acc   = r_acc[r_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_capture   = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: if (!w_stall) begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (!r_s1_valid && !r_out_valid) begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);

  // Rounding shift is 31 + q_shift; adding half an LSB before the arithmetic
  // shift rounds ties toward +inf.
  assign w_shift    = 6'd31 + {1'b0, r_q_shift};
  assign w_prod_ext = WW'(r_s1_prod);
  assign w_half     = WW'(1) <<< (w_shift - 6'd1);
  assign w_sum      = w_prod_ext + w_half;
  assign w_rnd      = w_sum >>> w_shift;
  assign w_v        = w_rnd + WW'(r_zp);
  assign w_min      = WW'(r_act_min);
  assign w_max      = WW'(r_act_max);

  always_comb begin
    w_clamped = w_v[OUT_W-1:0];
    if (w_v < w_min)      w_clamped = r_act_min;
    else if (w_v > w_max) w_clamped = r_act_max;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N*N; i++) r_acc[i] <= '0;
      r_mask      <= '0;
      r_q_mult    <= '0;
      r_q_shift   <= '0;
      r_zp        <= '0;
      r_act_min   <= '0;
      r_act_max   <= '0;
      r_idx       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_prod   <= '0;
      r_s1_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
    end else begin
      if (w_capture) begin
        for (int c = 0; c < N; c++) begin
          r_acc[c]       <= C0[c*ACC_W +: ACC_W];
          r_acc[N+c]     <= C1[c*ACC_W +: ACC_W];
          r_acc[2*N+c]   <= C2[c*ACC_W +: ACC_W];
          r_acc[3*N+c]   <= C3[c*ACC_W +: ACC_W];
        end
        r_mask    <= pe_mask;
        r_q_mult  <= q_mult;
        r_q_shift <= q_shift;
        r_zp      <= out_zp;
        r_act_min <= act_min;
        r_act_max <= act_max;
        r_idx     <= '0;
      end else if (w_step) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      // A stalled output freezes the whole pipe so nothing is dropped or repeated.
      if (!w_stall) begin
        r_s1_valid  <= w_step && r_mask[r_idx];
        r_s1_prod   <= PW'(w_acc) * PW'(r_q_mult);
        r_s1_idx    <= r_idx;
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_clamped;
          r_out_idx  <= r_s1_idx;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_row   = r_out_idx[IDX_W-1 -: RC_W];
  assign out_col   = r_out_idx[RC_W-1:0];

endmodule

// File: tb/tb_sta_output_requantizer.sv
// tb_sta_output_requantizer: directed vectors with hand-computed int8 results for the
// requantizer, covering latency, rounding, clamping, backpressure, masking and reset abort.
module tb_sta_output_requantizer;

  logic         clk = 1'b0;
  logic         reset_n, start;
  logic [127:0] C0, C1, C2, C3;
  logic [15:0]  pe_mask;
  logic [31:0]  q_mult;
  logic [4:0]   q_shift;
  logic [7:0]   out_zp, act_min, act_max;
  logic         out_valid, out_ready;
  logic [7:0]   out_data;
  logic [1:0]   out_row, out_col;
  logic         busy, done;

  logic [31:0]  acc [16];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_data[$];
  int         got_idx[$];
  int         got_cyc[$];
  int         done_cyc, first_valid_cyc, valid_cnt;

  sta_output_requantizer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .C0(C0), .C1(C1), .C2(C2), .C3(C3),
    .pe_mask(pe_mask), .q_mult(q_mult), .q_shift(q_shift),
    .out_zp(out_zp), .act_min(act_min), .act_max(act_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    C0 = '0; C1 = '0; C2 = '0; C3 = '0;
    for (int c = 0; c < 4; c++) begin
      C0[c*32 +: 32] = acc[c];
      C1[c*32 +: 32] = acc[4+c];
      C2[c*32 +: 32] = acc[8+c];
      C3[c*32 +: 32] = acc[12+c];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] mult, input logic [4:0] sh, input logic [7:0] zp,
                         input logic [7:0] amin, input logic [7:0] amax, input logic [15:0] mask);
    q_mult = mult; q_shift = sh; out_zp = zp; act_min = amin; act_max = amax; pe_mask = mask;
  endtask

  task automatic ramp_acc();
    for (int i = 0; i < 16; i++) acc[i] = 32'(2*i);
  endtask

  // Starts a tile and watches it until done; rdy_mode 0 = always ready, 1 = random.
  task automatic run_tile(input int rdy_mode, input int restart_cyc, input int budget);
    logic [7:0] prev_data;
    logic [3:0] prev_pos;
    logic       prev_stall;
    int         cyc;
    got_data.delete(); got_idx.delete(); got_cyc.delete();
    done_cyc = -1; first_valid_cyc = -1; valid_cnt = 0; prev_stall = 1'b0;
    prev_data = '0; prev_pos = '0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_cyc);
      out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_pos", {out_row, out_col}, prev_pos);
        check("stall_valid", out_valid, 1);
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_ready) begin
          got_data.push_back(out_data);
          got_idx.push_back(int'({out_row, out_col}));
          got_cyc.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_pos   = {out_row, out_col};
      if (cyc == 1) check("busy_rise", busy, 1);
      if (done) begin
        done_cyc = cyc;
        check("busy_at_done", busy, 1);
      end
    end
    check("done_seen", 32'(done_cyc >= 0), 1);
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  task automatic expect_out(input string tag, input int k, input int exp_idx, input logic [7:0] exp_data);
    if (k < got_idx.size()) begin
      check({tag, "_pos"}, got_idx[k], exp_idx);
      check({tag, "_data"}, got_data[k], exp_data);
    end else begin
      check({tag, "_count"}, got_idx.size(), k + 1);
    end
  endtask

  task automatic check_full_ramp(input string tag);
    check({tag, "_count"}, got_idx.size(), 16);
    for (int k = 0; k < 16; k++) expect_out(tag, k, k, 8'(k));
    check({tag, "_first_valid"}, first_valid_cyc, 3);
    if (got_cyc.size() == 16) check({tag, "_last_hs"}, got_cyc[15], 18);
    check({tag, "_done_cyc"}, done_cyc, 19);
  endtask

  initial begin
    int hs, cyc, idle_bad;
    logic stalled;
    int exp4 [8] = '{0, 2, 5, 7, 8, 10, 13, 15};

    reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) acc[i] = '0;
    set_cfg(32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F, 16'hFFFF);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_pos", {out_row, out_col}, 0);

    // 1: ramp, outputs equal the element index
    ramp_acc();
    run_tile(0, -1, 60);
    check_full_ramp("t1");

    // 2: rounding ties toward +inf
    for (int i = 0; i < 16; i++) acc[i] = '0;
    acc[0] = 32'd100; acc[1] = 32'd101; acc[2] = -32'sd101; acc[3] = -32'sd100;
    set_cfg(32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F, 16'h000F);
    run_tile(0, -1, 60);
    check("t2_count", got_idx.size(), 4);
    expect_out("t2_100", 0, 0, 8'd50);
    expect_out("t2_101", 1, 1, 8'd51);
    expect_out("t2_m101", 2, 2, 8'hCE);
    expect_out("t2_m100", 3, 3, 8'hCE);
    check("t2_done_cyc", done_cyc, 17);

    // 3: saturation and ReLU-style clamp
    acc[0] = 32'd1000; acc[1] = -32'sd1000; acc[2] = 32'd50; acc[3] = '0;
    set_cfg(32'h7FFF_FFFF, 5'd0, 8'd10, 8'h80, 8'h7F, 16'h0007);
    run_tile(0, -1, 60);
    check("t3_count", got_idx.size(), 3);
    expect_out("t3_sat_hi", 0, 0, 8'h7F);
    expect_out("t3_sat_lo", 1, 1, 8'h80);
    expect_out("t3_mid", 2, 2, 8'd60);
    acc[0] = -32'sd5; acc[1] = 32'd20; acc[2] = '0;
    set_cfg(32'h7FFF_FFFF, 5'd0, 8'd10, 8'd10, 8'h7F, 16'h0003);
    run_tile(0, -1, 60);
    check("t3r_count", got_idx.size(), 2);
    expect_out("t3r_relu", 0, 0, 8'd10);
    expect_out("t3r_pass", 1, 1, 8'd30);

    // extra right shift with negative zero point
    acc[0] = 32'd1004; acc[1] = 32'd1002; acc[2] = -32'sd1004; acc[3] = '0;
    set_cfg(32'h4000_0000, 5'd2, 8'hFD, 8'h80, 8'h7F, 16'h0007);
    run_tile(0, -1, 60);
    check("tsh_count", got_idx.size(), 3);
    expect_out("tsh_a", 0, 0, 8'd123);
    expect_out("tsh_b", 1, 1, 8'd122);
    expect_out("tsh_c", 2, 2, 8'h80);

    // 4: sparse mask under random backpressure
    ramp_acc();
    set_cfg(32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F, 16'hA5A5);
    run_tile(1, -1, 300);
    check("t4_count", got_idx.size(), 8);
    check("t4_valid_seen", 32'(valid_cnt >= 8), 1);
    for (int k = 0; k < 8; k++) expect_out("t4", k, exp4[k], 8'(exp4[k]));

    // 5: empty mask, then starts while busy and coincident with done
    set_cfg(32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F, 16'h0000);
    run_tile(0, -1, 60);
    check("t5_no_valid", valid_cnt, 0);
    check("t5_done_cyc", done_cyc, 17);
    set_cfg(32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F, 16'hFFFF);
    run_tile(0, 6, 60);
    check_full_ramp("t5b");
    run_tile(0, 19, 60);
    check_full_ramp("t5c");
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || out_valid || done) idle_bad++;
    end
    check("t5_idle_after", idle_bad, 0);

    // 6: reset during the 6th output stall, then a clean tile
    hs = 0; cyc = 0; stalled = 1'b0;
    @(negedge clk);
    start = 1'b1;
    while (!stalled && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      out_ready = (hs < 5);
      if (out_valid && !out_ready) stalled = 1'b1;
      else if (out_valid && out_ready) hs++;
    end
    check("t6_stall_reached", 32'(stalled), 1);
    @(negedge clk);
    check("t6_hold_data", out_data, 8'd5);
    check("t6_hold_pos", {out_row, out_col}, 4'd5);
    check("t6_hold_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_idle_done", done, 0);
    run_tile(0, -1, 60);
    check_full_ramp("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
